// File: rtl/ps2_device_tx_if.sv
// Byte-push handshake into the PS/2 device transmitter.
// A byte is transferred on a rising clk edge where tx_valid && tx_ready;
// tx_valid while tx_ready is low is ignored (no overwrite, no retry memory).
interface ps2_device_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: 4-entry byte FIFO feeding an 11-bit frame
// generator (start, 8 data LSB first, odd parity, stop). The device drives
// the PS/2 clock; the host may inhibit by holding the clock line low.
module ps2_device_tx #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic           clk,
    input  logic           resetn,
    ps2_device_tx_if.slave tx_if,
    input  logic           ps2_clk_in,
    output logic           ps2_clk_o,
    output logic           ps2_data_o,
    output logic           busy,
    output logic           frame_done,
    output logic           frame_abort,
    output logic [1:0]     dbg_state
);

    localparam logic [15:0] HP_LAST  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BIT_HIGH = 2'd1,
        S_BIT_LOW  = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [3:0]  r_idx;
    logic [7:0]  r_byte;
    logic        r_ps2_clk;
    logic        r_ps2_data;
    logic        r_done;
    logic        r_abort;

    logic        r_clk_meta;
    logic        r_clk_s;

    logic [7:0]  r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic        r_nempty;

    logic        w_ready;
    logic        w_push;
    logic        w_pop;
    logic        w_half_end;
    logic        w_gap_end;
    logic [3:0]  w_next_idx;
    logic [10:0] w_frame;

    assign w_ready    = (r_count != 3'd4);
    assign w_push     = tx_if.tx_valid && w_ready;
    assign w_half_end = (r_cnt == HP_LAST);
    assign w_gap_end  = (r_cnt == GAP_LAST);
    // The head byte leaves the FIFO only when its stop bit has completed.
    assign w_pop      = (r_state == S_BIT_LOW) && w_half_end && (r_idx == 4'd10);
    assign w_next_idx = r_idx + 4'd1;
    assign w_frame    = {1'b1, ~^r_byte, r_byte, 1'b0};

    assign tx_if.tx_ready = w_ready;
    assign ps2_clk_o      = r_ps2_clk;
    assign ps2_data_o     = r_ps2_data;
    assign frame_done     = r_done;
    assign frame_abort    = r_abort;
    assign busy           = (r_state == S_BIT_HIGH) || (r_state == S_BIT_LOW);
    assign dbg_state      = r_state;

    // Two-flop synchronizer for the asynchronous sensed clock line.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clk_meta <= 1'b1;
            r_clk_s    <= 1'b1;
        end else begin
            r_clk_meta <= ps2_clk_in;
            r_clk_s    <= r_clk_meta;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    // FIFO pointers and occupancy; r_nempty is a registered copy so a fresh
    // byte starts its frame two edges after the push.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_nempty <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            r_nempty <= (r_count != 3'd0);
        end
    end

    // Frame FSM with registered line levels and completion/abort pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_idx      <= 4'd0;
            r_byte     <= 8'd0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_nempty && r_clk_s) begin
                        r_state    <= S_BIT_HIGH;
                        r_cnt      <= 16'd0;
                        r_idx      <= 4'd0;
                        r_byte     <= r_mem[r_rd_ptr];
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b0;
                    end
                end
                S_BIT_HIGH: begin
                    // Host inhibit aborts unless we are already on the stop bit.
                    if (!r_clk_s && (r_idx <= 4'd9)) begin
                        r_state    <= S_GAP;
                        r_cnt      <= 16'd0;
                        r_ps2_clk  <= 1'b1;
                        r_ps2_data <= 1'b1;
                        r_abort    <= 1'b1;
                    end else if (w_half_end) begin
                        r_state   <= S_BIT_LOW;
                        r_cnt     <= 16'd0;
                        r_ps2_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_BIT_LOW: begin
                    if (w_half_end) begin
                        r_cnt     <= 16'd0;
                        r_ps2_clk <= 1'b1;
                        if (r_idx == 4'd10) begin
                            r_state    <= S_GAP;
                            r_ps2_data <= 1'b1;
                            r_done     <= 1'b1;
                        end else begin
                            r_state    <= S_BIT_HIGH;
                            r_idx      <= w_next_idx;
                            r_ps2_data <= w_frame[w_next_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx with HALF_PERIOD=4, GAP_CYCLES=8. A line monitor
// decodes frames on falling PS/2 clock edges into got_q; scenario tasks push
// expected frames into exp_q when they drive bytes and compare on output.
module tb_ps2_device_tx;

    localparam int HP  = 4;
    localparam int GAP = 8;

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_clk_o;
    logic       ps2_data_o;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;
    logic [1:0] dbg_state;

    ps2_device_tx_if u_if ();

    ps2_device_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .tx_if       (u_if),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_clk_o   (ps2_clk_o),
        .ps2_data_o  (ps2_data_o),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] exp_q [$];
    logic [10:0] got_q [$];

    // Line monitor
    int          mon_cnt      = 0;
    int          done_cnt     = 0;
    int          abort_cnt    = 0;
    logic        mon_prev_clk = 1'b1;
    logic [10:0] mon_bits     = '0;

    always @(negedge clk) begin
        if (!resetn || frame_abort) begin
            mon_cnt = 0;
        end else if (mon_prev_clk && !ps2_clk_o) begin
            mon_bits[mon_cnt] = ps2_data_o;
            mon_cnt++;
            if (mon_cnt == 11) begin
                got_q.push_back(mon_bits);
                mon_cnt = 0;
            end
        end
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        mon_prev_clk = ps2_clk_o;
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    // Driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt >= target) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_bit_high(input int idx, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (mon_cnt == idx && ps2_clk_o) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // Scenarios
    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        n_checks++; if (ps2_clk_o !== 1'b1) begin n_fail++; $display("FAIL reset_clk: got %b want 1", ps2_clk_o); end
        n_checks++; if (ps2_data_o !== 1'b1) begin n_fail++; $display("FAIL reset_data: got %b want 1", ps2_data_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frame_done !== 1'b0 || frame_abort !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got %b%b want 00", frame_done, frame_abort); end
        n_checks++; if (u_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", u_if.tx_ready); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        resetn = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_single();
        int          start;
        bit          to;
        int          base;
        logic [10:0] g;
        logic [10:0] e;
        base = done_cnt;
        push_byte(8'h1C);
        exp_q.push_back(frame_of(8'h1C));
        n_checks++; if (ps2_data_o !== 1'b1) begin n_fail++; $display("FAIL latency_n: got %b want 1", ps2_data_o); end
        tick();
        n_checks++; if (ps2_data_o !== 1'b1) begin n_fail++; $display("FAIL latency_n1: got %b want 1", ps2_data_o); end
        tick();
        n_checks++; if (ps2_data_o !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL latency_n2: got data=%b busy=%b want 0 1", ps2_data_o, busy); end
        start = cyc;
        wait_done(base + 1, 300, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_timeout: got no frame_done want one"); end
        n_checks++; if (cyc - start !== 88) begin n_fail++; $display("FAIL single_duration: got %0d want 88", cyc - start); end
        n_checks++; if (ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_end_lines: got %b%b busy=%b want 11 0", ps2_clk_o, ps2_data_o, busy); end
        n_checks++;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL single_frame: got %0d frames want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL single_frame: got %b want %b", g, e); end
            n_checks++; if (g !== 11'b10000111000) begin n_fail++; $display("FAIL single_bits: got %b want 10000111000", g); end
        end
        repeat (GAP + 4) tick();
    endtask

    task automatic test_back_to_back();
        bit          to;
        int          base;
        int          gap_n;
        logic [10:0] g;
        logic [10:0] e;
        base = done_cnt;
        push_byte(8'hF0);
        exp_q.push_back(frame_of(8'hF0));
        push_byte(8'h00);
        exp_q.push_back(frame_of(8'h00));
        wait_done(base + 1, 300, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_first_timeout: got no frame_done want one"); end
        gap_n = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ps2_clk_o && ps2_data_o) gap_n++;
            else break;
        end
        n_checks++; if (gap_n !== GAP) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles want %0d", gap_n, GAP); end
        wait_done(base + 2, 300, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL b2b_second_timeout: got %0d done want %0d", done_cnt - base, 2); end
        repeat (GAP + 4) tick();
        n_checks++; if (done_cnt - base !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - base); end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_frame: got no frame for entry %0d", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL b2b_frame: got %b want %b", g, e); end
                n_checks++; if (g[9] !== 1'b1) begin n_fail++; $display("FAIL b2b_parity: got %b want 1", g[9]); end
            end
        end
    endtask

    task automatic test_fifo_full();
        bit          to;
        int          base;
        int          occ;
        logic [7:0]  b;
        logic [10:0] g;
        logic [10:0] e;
        ps2_clk_in = 1'b0;
        repeat (3) tick();
        occ = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            n_checks++; if (u_if.tx_ready !== (occ < 4)) begin n_fail++; $display("FAIL full_ready_%0d: got %b want %b", i, u_if.tx_ready, occ < 4); end
            push_byte(b);
            if (occ < 4) begin
                exp_q.push_back(frame_of(b));
                occ++;
            end
        end
        n_checks++; if (u_if.tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_after: got %b want 0", u_if.tx_ready); end
        repeat (20) tick();
        n_checks++; if (busy !== 1'b0 || ps2_data_o !== 1'b1) begin n_fail++; $display("FAIL inhibit_idle: got busy=%b data=%b want 0 1", busy, ps2_data_o); end
        base = done_cnt;
        ps2_clk_in = 1'b1;
        wait_done(base + 4, 600, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL full_timeout: got %0d done want 4", done_cnt - base); end
        repeat (GAP + 20) tick();
        n_checks++; if (done_cnt - base !== 4) begin n_fail++; $display("FAIL full_done_count: got %0d want 4", done_cnt - base); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL full_frame: missing frame %0d", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g !== e) begin n_fail++; $display("FAIL full_frame_%0d: got %b want %b", k, g, e); end
            end
        end
        n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL full_extra: got %0d extra frames want 0", got_q.size()); got_q.delete(); end
        n_checks++; if (u_if.tx_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_end: got %b want 1", u_if.tx_ready); end
    endtask

    task automatic test_abort();
        bit          to;
        int          base_d;
        int          base_a;
        logic [10:0] g;
        logic [10:0] e;
        base_d = done_cnt;
        base_a = abort_cnt;
        push_byte(8'h1C);
        exp_q.push_back(frame_of(8'h1C));
        wait_bit_high(4, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL abort_reach_bit3: got mon_cnt=%0d want 4", mon_cnt); end
        ps2_clk_in = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (abort_cnt > base_a) begin to = 1'b0; break; end
        end
        n_checks++; if (to) begin n_fail++; $display("FAIL abort_pulse: got %0d aborts want 1", abort_cnt - base_a); end
        n_checks++; if (ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_lines: got %b%b busy=%b want 11 0", ps2_clk_o, ps2_data_o, busy); end
        ps2_clk_in = 1'b1;
        n_checks++; if (done_cnt !== base_d || got_q.size() !== 0) begin n_fail++; $display("FAIL abort_no_done: got done=%0d frames=%0d want 0 0", done_cnt - base_d, got_q.size()); end
        wait_done(base_d + 1, 400, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL abort_resend_timeout: got no frame_done want one"); end
        repeat (GAP + 20) tick();
        n_checks++; if (done_cnt - base_d !== 1 || abort_cnt - base_a !== 1) begin n_fail++; $display("FAIL abort_counts: got done=%0d abort=%0d want 1 1", done_cnt - base_d, abort_cnt - base_a); end
        n_checks++;
        if (got_q.size() == 0 || exp_q.size() == 0) begin
            n_fail++; $display("FAIL abort_resent_frame: got no frame want one");
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== e) begin n_fail++; $display("FAIL abort_resent_frame: got %b want %b", g, e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int base_d;
        bit saw_busy;
        base_d = done_cnt;
        push_byte(8'hA5);
        wait_bit_high(6, 200, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL rst_reach_bit5: got mon_cnt=%0d want 6", mon_cnt); end
        resetn = 1'b0;
        tick();
        n_checks++; if (ps2_clk_o !== 1'b1 || ps2_data_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_lines: got %b%b want 11", ps2_clk_o, ps2_data_o); end
        n_checks++; if (u_if.tx_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_status: got ready=%b busy=%b want 1 0", u_if.tx_ready, busy); end
        n_checks++; if (dbg_state !== 2'd0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got state=%0d done=%b want 0 0", dbg_state, frame_done); end
        resetn = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        n_checks++; if (saw_busy) begin n_fail++; $display("FAIL rst_mid_restart: got busy after reset want idle"); end
        n_checks++; if (done_cnt !== base_d || got_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got done=%0d frames=%0d want 0 0", done_cnt - base_d, got_q.size()); end
    endtask

    // Sequence and final report
    initial begin
        u_if.tx_data  = 8'h00;
        u_if.tx_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_abort();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 Parameter HALF_PERIOD, default 2500, system-clock cycles per PS/2 clock half-period (20 kHz at 100 MHz); legal range 2..65535.
REQ-002 Parameter GAP_CYCLES, default 5000, idle-high cycles between frames and after an abort; legal range 1..65535.
REQ-003 clk  input  1  system clock; single clock domain, all state on its rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 tx_data  input  8  scan-code byte to send.
REQ-006 tx_valid  input  1  tx_data valid this cycle.
REQ-007 tx_ready  output  1  FIFO can accept a byte; high when FIFO not full.
REQ-008 ps2_clk_in  input  1  sensed PS/2 clock line level (host may hold it low); asynchronous.
REQ-009 ps2_clk_o  output  1  driven PS/2 clock level; idle 1.
REQ-010 ps2_data_o  output  1  driven PS/2 data level; idle 1.
REQ-011 busy  output  1  high while a frame is in progress (BIT_HIGH or BIT_LOW).
REQ-012 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-013 frame_abort  output  1  one-cycle pulse when a frame is aborted by host inhibit.

Function
REQ-014 4-entry byte FIFO; push when tx_valid && tx_ready; tx_valid while full is ignored, no overwrite.
REQ-015 Head byte is popped only on frame_done; an aborted byte stays at the head and is resent.
REQ-016 ps2_clk_in passes through a 2-flop synchronizer before any use (clk_s).
REQ-017 Frame: 11 bits in order start(0), data[0]..data[7] LSB first, odd parity (~^data), stop(1).
REQ-018 FSM states: IDLE, BIT_HIGH, BIT_LOW, GAP.
REQ-019 IDLE -> BIT_HIGH when FIFO non-empty and clk_s==1; bit index=0, ps2_data_o=start bit on that edge.
REQ-020 BIT_HIGH: ps2_clk_o=1, lasts HALF_PERIOD cycles, then -> BIT_LOW.
REQ-021 BIT_LOW: ps2_clk_o=0, lasts HALF_PERIOD cycles; ps2_data_o stable through it (host samples on falling edge).
REQ-022 End of BIT_LOW with index<10: index+1, ps2_data_o=next bit, -> BIT_HIGH; data changes only on this transition.
REQ-023 End of BIT_LOW with index==10: ps2_clk_o=1, ps2_data_o=1, frame_done pulse, pop, -> GAP.
REQ-024 Frame duration: exactly 22*HALF_PERIOD cycles from leaving IDLE to entering GAP.
REQ-025 GAP: both outputs 1 for GAP_CYCLES cycles, then -> IDLE.
REQ-026 Inhibit: clk_s==0 in any BIT_HIGH cycle with index<=9 -> abort at once: outputs 1, frame_abort pulse, no pop, -> GAP.
REQ-027 Inhibit during the stop bit (index==10) is ignored; the frame completes.
REQ-028 IDLE with clk_s==0: stays in IDLE; no frame starts.
REQ-029 Latency: byte pushed into empty FIFO at edge N, FSM idle, clk_s==1 -> ps2_data_o=0 from edge N+2.
REQ-030 Push and pop in the same cycle: both occur, occupancy unchanged; FIFO pointers are 2-bit and wrap, occupancy is 3-bit (0..4).
REQ-031 busy = (state==BIT_HIGH || state==BIT_LOW).

Reset
REQ-032 resetn==0 at a rising edge: state IDLE, FIFO empty, counters 0, ps2_clk_o=1, ps2_data_o=1, busy=0, frame_done=0, frame_abort=0, tx_ready=1.
REQ-033 Reset mid-frame: the frame is dropped with no pulse; lines idle-high on the next edge.

Verification (HALF_PERIOD=4, GAP_CYCLES=8)
REQ-034 Push 0x1C -> falling-edge data samples 0,0,0,1,1,1,0,0,0,0,1 (parity 0); frame_done 88 cycles after start.
REQ-035 Push 0xF0 then 0x00 back-to-back -> parity bits 1 and 1; 8 idle cycles between frames; two frame_done pulses.
REQ-036 Push 5 bytes with the FSM idle but clk_s held 0 -> tx_ready drops after the 4th push; 5th byte ignored; release clk -> 4 frames in push order.
REQ-037 Hold ps2_clk_in low during the BIT_HIGH of data bit 3 of 0x1C -> frame_abort pulse, lines 1; after gap, 0x1C resent in full; one frame_done.
REQ-038 Assert resetn=0 during data bit 5 -> next edge: lines 1, tx_ready=1, busy=0; no frame_done.
